ticket_bcd_counter: RTL

TICKET_BCD_COUNTER -- requirements
Module: ticket_bcd_counter

---
 rtl/ticket_bcd_counter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ticket_bcd_counter.sv
// Ticket counter: four packed BCD digits with edge-detected inc/dec.
// Optional macro TICKET_WRAP_EN: wrap at the limits instead of saturating.
module ticket_bcd_counter #(
  parameter logic [15:0] MAX_COUNT = 16'h9999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       full,
  output logic       empty,
  output logic       err
);

  logic [15:0] cnt;
  logic [15:0] cnt_up;
  logic [15:0] cnt_dn;
  logic        inc_q;
  logic        dec_q;
  logic        err_q;
  logic        inc_ev;
  logic        dec_ev;
  logic        up;
  logic        dn;

  // Digit-serial +1: a 9 rolls to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Digit-serial -1: a 0 rolls to 9 and borrows upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign inc_ev = inc & ~inc_q;
  assign dec_ev = dec & ~dec_q;
  // Coincident events cancel out.
  assign up     = inc_ev & ~dec_ev;
  assign dn     = dec_ev & ~inc_ev;

  assign cnt_up = bcd_inc(cnt);
  assign cnt_dn = bcd_dec(cnt);

  assign full   = (cnt == MAX_COUNT);
  assign empty  = (cnt == 16'h0000);

  assign bcd0   = cnt[3:0];
  assign bcd1   = cnt[7:4];
  assign bcd2   = cnt[11:8];
  assign bcd3   = cnt[15:12];
  assign err    = err_q;

  // Count, edge-detect history and rejection flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 16'h0000;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      err_q <= 1'b0;
      if (clr) begin
        cnt <= 16'h0000;
      end else if (up) begin
        if (!full) begin
          cnt <= cnt_up;
        end else begin
`ifdef TICKET_WRAP_EN
          cnt <= 16'h0000;
`else
          err_q <= 1'b1;
`endif
        end
      end else if (dn) begin
        if (!empty) begin
          cnt <= cnt_dn;
        end else begin
`ifdef TICKET_WRAP_EN
          cnt <= MAX_COUNT;
`else
          err_q <= 1'b1;
`endif
        end
      end
    end
  end

endmodule
